alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-003 START  input  1  request pulse; sampled only in IDLE or DONE state.
REQ-004 OPCODE  input  3  op select, CPU SELECT encoding: 100 ROR, 101 MUL, 110 SRA, 111 SL; 0xx illegal.
REQ-005 DATA1  input  8  operand (register value); captured at accepted START.
REQ-006 DATA2  input  8  immediate: shift amount or multiplier; captured at accepted START.
REQ-007 RESULT  output  8  registered result; holds until next DONE.
REQ-008 ZERO  output  1  registered, (RESULT == 0), updated together with RESULT.
REQ-009 BUSY  output  1  high in RUN state; CPU stalls on it.
REQ-010 DONE  output  1  high for exactly one cycle (DONE state).
REQ-011 ILLEGAL  output  1  high together with DONE when the completed op had OPCODE[2]=0.

Function
REQ-012 States: IDLE, RUN, DONE; registered state, one-hot or binary is free.
REQ-013 IDLE or DONE and START=1 at edge k: capture OPCODE/DATA1/DATA2, load step count N; N>0 -> RUN, N=0 -> DONE.
REQ-014 N: MUL 8; ROR DATA2[2:0]; SRA and SL min(|DATA2|,8), DATA2 read as signed for SL, unsigned for SRA; |-128| saturates to 8.
REQ-015 RUN: one step per edge, count decrements; the edge with count==1 writes RESULT/ZERO and moves to DONE; DONE visible after edge k+N.
REQ-016 MUL step (LSB-first shift-add): ACC += MPLR[0] ? MCAND : 0; MCAND <<= 1; MPLR >>= 1; RESULT = low 8 bits of product, overflow discarded.
REQ-017 SRA step: shift right 1, replicate bit 7; amounts >=8 give all copies of sign.
REQ-018 SL step: DATA2 >= 0 logical left 1; DATA2 < 0 logical right 1; zeros shifted in; magnitude >=8 gives 8'h00.
REQ-019 ROR step: rotate right 1; amount modulo 8.
REQ-020 N=0 ops (ROR/SL/SRA with zero amount): RESULT = DATA1 at DONE.
REQ-021 Illegal OPCODE: N=0, RESULT = 8'h00, ZERO=1, ILLEGAL=1 during DONE.
REQ-022 START during RUN ignored; no queueing; DATA1/DATA2/OPCODE changes during RUN have no effect.
REQ-023 START in DONE cycle accepted (back-to-back); DONE still lasts one cycle, next state per REQ-013.
REQ-024 DONE without START -> IDLE next edge.
REQ-025 BUSY = (state==RUN); DONE and BUSY never high together.

Reset
REQ-026 RESET=1 at an edge: state IDLE, RESULT 8'h00, ZERO 1, BUSY 0, DONE 0, ILLEGAL 0, internal regs cleared; overrides START.
REQ-027 RESET mid-RUN discards the operation; no DONE is produced for it.
REQ-028 First START after RESET deasserts is accepted normally.

Structure
REQ-029 Shared include/package holds OPCODE encodings (matching ALU SELECT values) and state encodings; no local redefinition.
REQ-030 One combinational sub-module alu_seq_step: inputs op, working regs, sign of amount; outputs next working regs; controller FSM and counter stay in alu_seq_ctrl.
REQ-031 No combinational path from inputs to outputs; all outputs registered.

Verification
REQ-032 MUL DATA1=13, DATA2=11 -> RESULT 8'h8F, ZERO 0, BUSY 8 cycles, DONE after edge k+8; 16x16 -> 8'h00, ZERO 1.
REQ-033 SRA DATA1=8'hA4, DATA2=2 -> 8'hE9 after 2 steps; DATA2=9 -> 8'hFF after 8 steps.
REQ-034 SL DATA1=8'h81, DATA2=3 -> 8'h08; DATA2=8'hFE (-2) -> 8'h20; DATA2=8'h80 -> 8'h00 after 8 steps.
REQ-035 ROR DATA1=8'h81, DATA2=1 -> 8'hC0; DATA2=9 -> 8'hC0; DATA2=0 -> 8'h81, DONE after edge k, BUSY never high.
REQ-036 RESET at 3rd RUN cycle of MUL -> next cycle all outputs at reset values, no DONE; following ROR request completes correctly.
REQ-037 START held high through MUL then SRA issued in DONE cycle -> RUN START pulses ignored, SRA accepted in DONE cycle, two DONE pulses, correct results; OPCODE 010 -> ILLEGAL+DONE, RESULT 8'h00.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the sequential ALU: CPU SELECT opcodes, FSM states,
// the working-register bundle and the step-count rule.
package alu_seq_ctrl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_STEPS = 8;

  localparam logic [OP_W-1:0] OP_ROR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_SRA = 3'b110;
  localparam logic [OP_W-1:0] OP_SL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // val: shifted operand / multiplicand, mplr: multiplier, acc: product
  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] mplr;
    logic [DATA_W-1:0] acc;
  } work_t;

  // Number of single-bit steps an op needs; 0 means the result is ready at once.
  function automatic logic [CNT_W-1:0] step_count(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] amt);
    logic [DATA_W-1:0] mag;
    logic [CNT_W-1:0]  n;
    mag = amt[DATA_W-1] ? DATA_W'(8'h00 - amt) : amt;
    n   = '0;
    case (op)
      OP_MUL:  n = CNT_W'(MAX_STEPS);
      OP_ROR:  n = CNT_W'(amt[2:0]);
      OP_SRA:  n = (amt >= DATA_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : CNT_W'(amt[3:0]);
      OP_SL:   n = (mag >= DATA_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : CNT_W'(mag[3:0]);
      default: n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/alu_seq_step.sv
// One combinational iteration of the sequential ALU datapath.
module alu_seq_step
  import alu_seq_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  work_t           i_work,
  input  logic            i_neg,
  output work_t           o_work
);

  always_comb begin
    o_work = i_work;
    case (i_op)
      OP_MUL: begin
        o_work.acc  = i_work.acc + (i_work.mplr[0] ? i_work.val : '0);
        o_work.val  = {i_work.val[DATA_W-2:0], 1'b0};
        o_work.mplr = {1'b0, i_work.mplr[DATA_W-1:1]};
      end
      OP_SRA: o_work.val = {i_work.val[DATA_W-1], i_work.val[DATA_W-1:1]};
      // negative amount on SL means logical right shift
      OP_SL:  o_work.val = i_neg ? {1'b0, i_work.val[DATA_W-1:1]}
                                 : {i_work.val[DATA_W-2:0], 1'b0};
      OP_ROR: o_work.val = {i_work.val[0], i_work.val[DATA_W-1:1]};
      default: o_work = i_work;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU controller: accepts a request, iterates the step datapath
// once per clock and publishes a registered result with a one-cycle DONE.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [OP_W-1:0]   OPCODE,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO,
  output logic              BUSY,
  output logic              DONE,
  output logic              ILLEGAL
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_n;
  logic [OP_W-1:0]    r_op, w_op_nxt;
  logic               r_neg, w_neg_nxt;
  work_t              r_work, w_work_nxt, w_step;
  logic [DATA_W-1:0]  r_result, w_result_nxt;
  logic               r_zero, r_busy, r_done, r_illegal, w_illegal_nxt;

  alu_seq_step u_step (
    .i_op   (r_op),
    .i_work (r_work),
    .i_neg  (r_neg),
    .o_work (w_step)
  );

  assign w_n = step_count(OPCODE, DATA2);

  // Next-state and datapath-load decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_op_nxt      = r_op;
    w_neg_nxt     = r_neg;
    w_work_nxt    = r_work;
    w_result_nxt  = r_result;
    w_illegal_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          w_op_nxt   = OPCODE;
          w_neg_nxt  = DATA2[DATA_W-1];
          w_work_nxt = '{val: DATA1, mplr: DATA2, acc: '0};
          w_cnt_nxt  = w_n;
          if (w_n == '0) begin
            w_state_nxt   = ST_DONE;
            w_result_nxt  = OPCODE[OP_W-1] ? DATA1 : '0;
            w_illegal_nxt = ~OPCODE[OP_W-1];
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_work_nxt = w_step;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = (r_op == OP_MUL) ? w_step.acc : w_step.val;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_work    <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_neg     <= w_neg_nxt;
      r_work    <= w_work_nxt;
      r_result  <= w_result_nxt;
      r_zero    <= (w_result_nxt == '0);
      r_busy    <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
      r_illegal <= w_illegal_nxt;
    end
  end

  assign RESULT  = r_result;
  assign ZERO    = r_zero;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ILLEGAL = r_illegal;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table plus hand-written
// reset-abort and back-to-back sequences, results checked via a scoreboard.
module tb_alu_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [2:0] OPCODE;
  logic [7:0] DATA1, DATA2, RESULT;
  logic       ZERO, BUSY, DONE, ILLEGAL;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] res;
    logic       ill;
    int         n;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       zero;
    logic       ill;
  } exp_t;

  localparam int NV = 20;
  vec_t vecs[NV];
  exp_t sb[$];

  alu_seq_ctrl dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
    .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input string name, input logic [7:0] res, input logic ill);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.zero = (res == 8'h00);
    e.ill  = ill;
    return e;
  endfunction

  // Scoreboard consumer: every DONE must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DONE && BUSY) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_busy_overlap: DONE=1 BUSY=1 expected never both");
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got DONE with result %0h expected no DONE", RESULT);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_result"}, RESULT, e.res);
          check({e.name, "_zero"}, ZERO, e.zero);
          check({e.name, "_illegal"}, ILLEGAL, e.ill);
        end
      end
    end
  end

  // Issue one request, then verify latency, BUSY span and return to IDLE.
  task automatic run_op(input vec_t v, input string name);
    int lat;
    int busy_cnt;
    @(negedge CLK);
    START = 1'b1; OPCODE = v.op; DATA1 = v.d1; DATA2 = v.d2;
    sb.push_back(mk_exp(name, v.res, v.ill));
    @(posedge CLK);
    #1;
    START = 1'b0;
    OPCODE = 3'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom);
    lat = -1;
    busy_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = j;
        break;
      end
      if (BUSY) busy_cnt++;
    end
    check({name, "_latency"}, lat, v.n);
    check({name, "_busy_cycles"}, busy_cnt, v.n);
    @(negedge CLK);
    check({name, "_idle_after"}, {DONE, BUSY}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b101, 8'd13,  8'd11,  8'h8F, 1'b0, 8};
    vecs[1]  = '{3'b101, 8'd16,  8'd16,  8'h00, 1'b0, 8};
    vecs[2]  = '{3'b101, 8'hFF,  8'hFF,  8'h01, 1'b0, 8};
    vecs[3]  = '{3'b110, 8'hA4,  8'd2,   8'hE9, 1'b0, 2};
    vecs[4]  = '{3'b110, 8'hA4,  8'd9,   8'hFF, 1'b0, 8};
    vecs[5]  = '{3'b110, 8'h40,  8'd3,   8'h08, 1'b0, 3};
    vecs[6]  = '{3'b110, 8'h7F,  8'h80,  8'h00, 1'b0, 8};
    vecs[7]  = '{3'b111, 8'h81,  8'd3,   8'h08, 1'b0, 3};
    vecs[8]  = '{3'b111, 8'h81,  8'hFE,  8'h20, 1'b0, 2};
    vecs[9]  = '{3'b111, 8'h81,  8'h80,  8'h00, 1'b0, 8};
    vecs[10] = '{3'b111, 8'h81,  8'hF9,  8'h01, 1'b0, 7};
    vecs[11] = '{3'b111, 8'h01,  8'd7,   8'h80, 1'b0, 7};
    vecs[12] = '{3'b100, 8'h81,  8'd1,   8'hC0, 1'b0, 1};
    vecs[13] = '{3'b100, 8'h81,  8'd9,   8'hC0, 1'b0, 1};
    vecs[14] = '{3'b100, 8'h81,  8'd0,   8'h81, 1'b0, 0};
    vecs[15] = '{3'b100, 8'h12,  8'h0F,  8'h24, 1'b0, 7};
    vecs[16] = '{3'b111, 8'h5A,  8'd0,   8'h5A, 1'b0, 0};
    vecs[17] = '{3'b110, 8'h00,  8'd0,   8'h00, 1'b0, 0};
    vecs[18] = '{3'b010, 8'h55,  8'd3,   8'h00, 1'b1, 0};
    vecs[19] = '{3'b000, 8'hFF,  8'hFF,  8'h00, 1'b1, 0};

    RESET = 1'b1; START = 1'b1; OPCODE = 3'b101; DATA1 = 8'd3; DATA2 = 8'd3;
    repeat (3) @(negedge CLK);
    check("reset_result", RESULT, 8'h00);
    check("reset_zero", ZERO, 1);
    check("reset_flags", {BUSY, DONE, ILLEGAL}, 0);
    START = 1'b0;
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset during the third RUN cycle of a MUL discards it.
    @(negedge CLK);
    START = 1'b1; OPCODE = 3'b101; DATA1 = 8'd13; DATA2 = 8'd11;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_busy_before", BUSY, 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_result", RESULT, 8'h00);
    check("abort_zero", ZERO, 1);
    check("abort_flags", {BUSY, DONE, ILLEGAL}, 0);
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      check("abort_no_done", DONE, 0);
    end
    run_op('{3'b100, 8'h81, 8'd1, 8'hC0, 1'b0, 1}, "after_abort_ror");

    // START held through MUL; SRA presented during RUN is taken in the DONE cycle.
    begin
      int ndone;
      int t0, t1;
      ndone = 0; t0 = -1; t1 = -1;
      @(negedge CLK);
      START = 1'b1; OPCODE = 3'b101; DATA1 = 8'd13; DATA2 = 8'd11;
      sb.push_back(mk_exp("b2b_mul", 8'h8F, 1'b0));
      sb.push_back(mk_exp("b2b_sra", 8'hE9, 1'b0));
      @(posedge CLK);
      #1;
      OPCODE = 3'b110; DATA1 = 8'hA4; DATA2 = 8'd2;
      for (int j = 0; j < 30 && ndone < 2; j++) begin
        @(negedge CLK);
        if (DONE) begin
          if (ndone == 0) t0 = j; else t1 = j;
          ndone++;
          if (ndone == 1) begin
            @(posedge CLK);
            #1 START = 1'b0;
          end
        end
      end
      START = 1'b0;
      check("b2b_done_count", ndone, 2);
      check("b2b_mul_latency", t0, 8);
      check("b2b_sra_latency", t1, 11);
      @(negedge CLK);
      check("b2b_idle_after", {DONE, BUSY}, 0);
    end

    run_op('{3'b010, 8'hAA, 8'h01, 8'h00, 1'b1, 0}, "illegal_010");
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
